fir_block_engine: RTL and testbench

- Compute stage between the read FSM (S_RD_*) and the write FSM (S_WR_*) of the FIR sample AFU.
- Consumes 512-bit t_block words fetched from the input buffer and applies an N-tap FIR across a continuous 32-bit sample stream.
- The stream carries filter history across block boundaries.
- Emits one filtered t_block per accepted input block to the write path, with a valid/ready handshake in both directions.

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_block_engine_if.sv | 26 ++
 rtl/fir_lane_mac.sv | 36 +++
 rtl/fir_block_engine.sv | 101 ++++++++++
 tb/tb_fir_block_engine.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR sample AFU compute path.
// A t_block is 512 bits: LANES 32-bit samples, lane 0 in the low bits and oldest in time.
package fir_pkg;

  localparam int FIR_NUM_TAPS = 8;
  localparam int FIR_LANES    = 16;

  typedef logic [511:0]        t_block;
  typedef logic signed [31:0]  t_sample;
  typedef t_sample             t_coef_bank [FIR_NUM_TAPS];

  function automatic t_sample fir_lane_sample(input t_block blk, input int idx);
    return t_sample'(blk[32*idx +: 32]);
  endfunction

endpackage

// File: rtl/fir_block_engine_if.sv
// Block stream between the read path, the FIR engine and the write path.
// Handshake: a transfer happens on a rising edge where valid & ready are both high.
// The source keeps valid and its payload stable until the transfer. Ready may depend on valid.
interface fir_block_engine_if;
  import fir_pkg::*;

  logic   in_valid;
  logic   in_ready;
  t_block in_block;
  logic   in_last;
  logic   out_valid;
  logic   out_ready;
  t_block out_block;
  logic   out_last;

  modport master (
    output in_valid, in_block, in_last, out_ready,
    input  in_ready, out_valid, out_block, out_last
  );

  modport slave (
    input  in_valid, in_block, in_last, out_ready,
    output in_ready, out_valid, out_block, out_last
  );

endinterface

// File: rtl/fir_lane_mac.sv
// One output lane of the FIR.
// Stage 1 registers the per-tap products, and stage 2 registers their wrapped 32-bit sum.
module fir_lane_mac
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = FIR_NUM_TAPS
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  t_sample window [NUM_TAPS],
  input  t_sample coef   [NUM_TAPS],
  output t_sample sum
);

  t_sample prod [NUM_TAPS];
  t_sample acc;

  // Only the low 32 bits of each product are kept.
  // The final sum wraps modulo 2^32, so the upper product bits never reach the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_TAPS; k++) prod[k] <= '0;
      sum <= '0;
    end else if (en) begin
      for (int k = 0; k < NUM_TAPS; k++) prod[k] <= window[k] * coef[k];
      sum <= acc;
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < NUM_TAPS; k++) acc = acc + prod[k];
  end

endmodule

// File: rtl/fir_block_engine.sv
// N-tap FIR over a continuous 32-bit sample stream that arrives as 512-bit blocks.
// Uses a two-stage pipeline, and the filter history carries across block boundaries.
module fir_block_engine
  import fir_pkg::*;
#(
  parameter  int NUM_TAPS = FIR_NUM_TAPS,
  localparam int IDX_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             coef_wr,
  input  logic [IDX_W-1:0] coef_idx,
  input  t_sample          coef_data,
  fir_block_engine_if.slave bus,
  output logic [31:0]      blocks_done,
  output logic             done
);

  localparam int LANES  = FIR_LANES;
  localparam int HIST_N = (NUM_TAPS > 1) ? NUM_TAPS - 1 : 1;
  localparam int EXT_N  = HIST_N + LANES;

  t_sample coef [NUM_TAPS];
  t_sample hist [HIST_N];
  t_sample ext  [EXT_N];
  t_sample sums [LANES];

  logic s1_valid, s1_last, s2_valid, s2_last;
  logic stall, accept, handoff;

  assign stall        = s2_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall & ~clear;
  assign accept       = bus.in_valid & bus.in_ready;
  assign handoff      = s2_valid & bus.out_ready;
  assign bus.out_valid = s2_valid;
  assign bus.out_last  = s2_last;

  // Extended stream: the history (oldest first) followed by the incoming block's lanes.
  always_comb begin
    for (int j = 0; j < HIST_N; j++) ext[j] = hist[j];
    for (int i = 0; i < LANES; i++)  ext[HIST_N + i] = fir_lane_sample(bus.in_block, i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_TAPS; k++) coef[k] <= '0;
    end else if (coef_wr && (int'(coef_idx) < NUM_TAPS)) begin
      coef[coef_idx] <= coef_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int j = 0; j < HIST_N; j++) hist[j] <= '0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s2_valid    <= 1'b0;
      s2_last     <= 1'b0;
      blocks_done <= '0;
      done        <= 1'b0;
    end else begin
      done <= handoff & s2_last;
      if (handoff) blocks_done <= blocks_done + 32'd1;
      if (!stall) begin
        s1_valid <= accept;
        s1_last  <= accept & bus.in_last;
        s2_valid <= s1_valid;
        s2_last  <= s1_last;
      end
      if (accept) begin
        for (int j = 0; j < HIST_N; j++) hist[j] <= ext[LANES + j];
      end
    end
  end

  // The lane data path keeps loading while not stalled.
  // Bubbles carry junk products, but their valid bit is low.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    t_sample win [NUM_TAPS];

    always_comb begin
      for (int k = 0; k < NUM_TAPS; k++) win[k] = ext[HIST_N + l - k];
    end

    fir_lane_mac #(.NUM_TAPS(NUM_TAPS)) u_mac (
      .clk    (clk),
      .reset  (reset),
      .en     (~stall),
      .window (win),
      .coef   (coef),
      .sum    (sums[l])
    );
  end

  always_comb begin
    bus.out_block = '0;
    for (int i = 0; i < LANES; i++) bus.out_block[32*i +: 32] = sums[i];
  end

endmodule

// File: tb/tb_fir_block_engine.sv
// Directed bench for fir_block_engine.
// Stimulus tasks push expected blocks into a queue, and a negedge monitor compares each handoff.
module tb_fir_block_engine;
  import fir_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        coef_wr;
  logic [2:0]  coef_idx;
  t_sample     coef_data;
  logic [31:0] blocks_done;
  logic        done;

  fir_block_engine_if bus();

  fir_block_engine #(.NUM_TAPS(8)) dut (
    .clk         (clk),
    .reset       (rst),
    .clear       (clear),
    .coef_wr     (coef_wr),
    .coef_idx    (coef_idx),
    .coef_data   (coef_data),
    .bus         (bus),
    .blocks_done (blocks_done),
    .done        (done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [512:0] exp_q[$];
  logic [512:0] mon_e;
  logic         done_exp = 1'b0;
  logic         mon_pend;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_pend = 1'b0;
      if (done_exp) check("done_pulse", 512'(done), 512'(1));
      else if (done) begin
        tests++;
        fails++;
        $display("FAIL done_spurious: got 1 expected 0");
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got %0h expected no block", bus.out_block);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_block", bus.out_block, mon_e[511:0]);
          check("out_last", 512'(bus.out_last), 512'(mon_e[512]));
          mon_pend = mon_e[512];
        end
      end
      done_exp = mon_pend;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int idx, input t_sample val);
    coef_wr   = 1'b1;
    coef_idx  = idx[2:0];
    coef_data = val;
    tick();
    coef_wr   = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic send_block(input t_block b, input logic last, input t_block exp, input bit push);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_block = b;
    bus.in_last  = last;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        if (push) exp_q.push_back({last, exp});
        tick();
        break;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: got in_ready 0 for 100 cycles expected 1");
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) tick();
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  function automatic t_block lane_blk(input int l, input logic [31:0] v);
    t_block b = '0;
    b[32*l +: 32] = v;
    return b;
  endfunction

  function automatic t_block seq_blk(input int base);
    t_block b = '0;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = 32'(base + i + 1);
    return b;
  endfunction

  // ---------------- stimulus ----------------
  t_block e;
  t_block held;
  bit     seen;

  initial begin
    rst = 1'b1; clear = 1'b0; coef_wr = 1'b0; coef_idx = '0; coef_data = '0;
    bus.in_valid = 1'b0; bus.in_block = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 512'(bus.out_valid), 512'(0));
    check("rst_in_ready", 512'(bus.in_ready), 512'(1));
    check("rst_blocks_done", 512'(blocks_done), 512'(0));
    check("rst_done", 512'(done), 512'(0));
    check("rst_out_block", bus.out_block, 512'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Impulse across the block boundary: c[k] = k+1.
    for (int k = 0; k < 8; k++) write_coef(k, 32'(k + 1));
    e = '0;
    for (int i = 0; i < 8; i++) e[32*i +: 32] = 32'(i + 1);
    send_block(lane_blk(0, 32'd1), 1'b0, e, 1'b1);
    send_block('0, 1'b0, '0, 1'b1);
    drain();
    check("impulse_blocks_done", 512'(blocks_done), 512'(2));

    // History carry: all coefficients 1, sample 5 in lane 15.
    pulse_clear();
    for (int k = 0; k < 8; k++) write_coef(k, 32'd1);
    send_block(lane_blk(15, 32'd5), 1'b0, lane_blk(15, 32'd5), 1'b1);
    e = '0;
    for (int i = 0; i < 7; i++) e[32*i +: 32] = 32'd5;
    send_block('0, 1'b0, e, 1'b1);
    drain();

    // Wrap arithmetic: 2 * 0x7FFFFFFF wraps to 0xFFFFFFFE.
    pulse_clear();
    write_coef(0, 32'd2);
    for (int k = 1; k < 8; k++) write_coef(k, 32'd0);
    send_block(lane_blk(0, 32'h7FFF_FFFF), 1'b0, lane_blk(0, 32'hFFFF_FFFE), 1'b1);
    drain();

    // Coefficient write in the acceptance cycle: the block uses the old value.
    pulse_clear();
    write_coef(0, 32'd1);
    coef_wr = 1'b1; coef_idx = 3'd0; coef_data = 32'd3;
    send_block(lane_blk(0, 32'd1), 1'b0, lane_blk(0, 32'd1), 1'b1);
    coef_wr = 1'b0;
    send_block(lane_blk(0, 32'd1), 1'b0, lane_blk(0, 32'd3), 1'b1);
    drain();

    // Backpressure: identity filter, four blocks, output held for five cycles.
    pulse_clear();
    write_coef(0, 32'd1);
    bus.out_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 4; b++) send_block(seq_blk(b * 16), 1'b0, seq_blk(b * 16), 1'b1);
      end
      begin
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (bus.out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("stall_out_valid_seen", 512'(seen), 512'(1));
        held = bus.out_block;
        for (int c = 0; c < 5; c++) begin
          if (c > 0) @(negedge clk);
          check("stall_in_ready", 512'(bus.in_ready), 512'(0));
          check("stall_hold", bus.out_block, held);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_blocks_done", 512'(blocks_done), 512'(4));

    // Clear while a block is stalled: the block is dropped and the history is flushed.
    pulse_clear();
    for (int k = 0; k < 8; k++) write_coef(k, 32'd1);
    bus.out_ready = 1'b0;
    send_block(lane_blk(15, 32'd9), 1'b0, '0, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("clr_stalled_seen", 512'(seen), 512'(1));
    @(posedge clk); #1;
    pulse_clear();
    @(negedge clk);
    check("clr_out_valid", 512'(bus.out_valid), 512'(0));
    check("clr_blocks_done", 512'(blocks_done), 512'(0));
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send_block('0, 1'b0, '0, 1'b1);
    drain();
    check("clr_after_blocks_done", 512'(blocks_done), 512'(1));

    // Last/done: three blocks through the identity filter, the third marked last.
    pulse_clear();
    write_coef(0, 32'd1);
    for (int k = 1; k < 8; k++) write_coef(k, 32'd0);
    for (int b = 0; b < 3; b++)
      send_block(seq_blk(100 + b * 16), (b == 2), seq_blk(100 + b * 16), 1'b1);
    drain();
    check("last_blocks_done", 512'(blocks_done), 512'(3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
